// File: rtl/instruction_fetch_unit_if.sv
// Instruction fetch bus bundle.
// It carries the imem read port, the decode valid/ready handshake and the
// redirect request.
// The master side is the fetch unit. The slave side is the memory/decode
// environment.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int INSTR_W = 32
);
  logic [ADDR_W-1:0]  imem_addr;
  logic [DATA_W-1:0]  imem_data;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [63:0]        instr_pc;
  logic               redirect_valid;
  logic [63:0]        redirect_pc;

  modport master (
    output imem_addr, instr_valid, instr, instr_pc,
    input  imem_data, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_addr, instr_valid, instr, instr_pc,
    output imem_data, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit.
// It owns the byte fetch PC and issues word reads to a memory with a fixed
// 1-cycle latency.
// Returned words are buffered in a 2-entry shift FIFO. The FIFO head flops
// drive the decode outputs directly.
// A redirect flushes the FIFO and drops any in-flight response.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          ADDR_W     = 64,
  parameter int          DATA_W     = 64,
  parameter int          INSTR_W    = 32,
  parameter int          FIFO_DEPTH = 2
) (
  input logic                      clk,
  input logic                      reset,
  instruction_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_e;

  fifo_state_e        state_q, state_d;
  logic [63:0]        fetch_pc_q, fetch_pc_d;
  logic [63:0]        req_pc_q, req_pc_d;
  logic               inflight_q, inflight_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] head_instr_q, head_instr_d;
  logic [63:0]        head_pc_q, head_pc_d;
  logic [INSTR_W-1:0] tail_instr_q, tail_instr_d;
  logic [63:0]        tail_pc_q, tail_pc_d;

  logic               pop_s;
  logic               push_s;
  logic               issue_s;
  logic [1:0]         count_s;
  logic [2:0]         occupancy_s;
  logic [DATA_W-1:0]  rsp_word_s;
  logic [INSTR_W-1:0] rsp_instr_s;
  logic [63:0]        word_addr_s;

  // The FIFO state encoding is the entry count.
  assign count_s     = state_q;
  assign pop_s       = valid_q & bus.instr_ready;
  // A redirect squashes the response that is arriving this cycle.
  assign push_s      = inflight_q & ~bus.redirect_valid;
  // Entries that will be occupied once the in-flight word lands.
  // Issue only when a slot is still free after that.
  assign occupancy_s = {1'b0, count_s} - {2'b00, pop_s} + {2'b00, inflight_q};
  assign issue_s     = ~bus.redirect_valid & (occupancy_s < 3'(FIFO_DEPTH));
  assign rsp_word_s  = bus.imem_data;
  assign rsp_instr_s = rsp_word_s[INSTR_W-1:0];
  assign word_addr_s = {2'b00, fetch_pc_q[63:2]};

  assign bus.imem_addr   = word_addr_s[ADDR_W-1:0];
  assign bus.instr_valid = valid_q;
  assign bus.instr       = head_instr_q;
  assign bus.instr_pc    = head_pc_q;

  // Fetch PC sequencing: redirect, issue a new word read, or hold.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    if (bus.redirect_valid) begin
      fetch_pc_d = {bus.redirect_pc[63:2], 2'b00};
      inflight_d = 1'b0;
    end else if (issue_s) begin
      inflight_d = 1'b1;
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 64'd4;
    end else begin
      inflight_d = 1'b0;
    end
  end

  // Output FIFO FSM: move entries according to push/pop, and flush on redirect.
  always_comb begin
    state_d      = state_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    tail_instr_d = tail_instr_q;
    tail_pc_d    = tail_pc_q;
    if (bus.redirect_valid) begin
      state_d      = EMPTY;
      head_instr_d = '0;
      head_pc_d    = 64'd0;
      tail_instr_d = '0;
      tail_pc_d    = 64'd0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push_s) begin
            state_d      = ONE;
            head_instr_d = rsp_instr_s;
            head_pc_d    = req_pc_q;
          end else begin
            state_d = EMPTY;
          end
        end
        ONE: begin
          case ({push_s, pop_s})
            2'b10: begin
              state_d      = FULL;
              tail_instr_d = rsp_instr_s;
              tail_pc_d    = req_pc_q;
            end
            2'b01: begin
              state_d      = EMPTY;
              head_instr_d = '0;
              head_pc_d    = 64'd0;
            end
            2'b11: begin
              head_instr_d = rsp_instr_s;
              head_pc_d    = req_pc_q;
            end
            default: state_d = ONE;
          endcase
        end
        FULL: begin
          case ({push_s, pop_s})
            2'b01: begin
              state_d      = ONE;
              head_instr_d = tail_instr_q;
              head_pc_d    = tail_pc_q;
              tail_instr_d = '0;
              tail_pc_d    = 64'd0;
            end
            2'b11: begin
              head_instr_d = tail_instr_q;
              head_pc_d    = tail_pc_q;
              tail_instr_d = rsp_instr_s;
              tail_pc_d    = req_pc_q;
            end
            default: state_d = FULL;
          endcase
        end
        default: state_d = EMPTY;
      endcase
    end
    valid_d = (state_d != EMPTY);
  end

  // State registers. Reset has priority over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= 64'd0;
      inflight_q   <= 1'b0;
      valid_q      <= 1'b0;
      head_instr_q <= '0;
      head_pc_q    <= 64'd0;
      tail_instr_q <= '0;
      tail_pc_q    <= 64'd0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      inflight_q   <= inflight_d;
      valid_q      <= valid_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      tail_instr_q <= tail_instr_d;
      tail_pc_q    <= tail_pc_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit.
// dut0 (RESET_PC=0) is checked every cycle against a queue-based model.
// Directed literal checks pin that model.
// dut1 (RESET_PC=...FFFC) checks PC wrap-around.
module tb_instruction_fetch_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instruction_fetch_unit_if bus0();
  instruction_fetch_unit_if bus1();

  instruction_fetch_unit #(.RESET_PC(64'h0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));
  instruction_fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  // Memory image: the low word is k+100 and the upper half is a marker.
  function automatic logic [63:0] mem_word(input logic [5:0] idx);
    return {32'hDEAD_0000 | {26'd0, idx}, 32'd100 + {26'd0, idx}};
  endfunction

  // 1-cycle latency memories, one per DUT.
  always @(posedge clk) bus0.imem_data <= mem_word(bus0.imem_addr[5:0]);
  always @(posedge clk) bus1.imem_data <= mem_word(bus1.imem_addr[5:0]);

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model state: buffered entries, byte fetch PC, and the outstanding request.
  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;
  ent_t        mq[$];
  logic [63:0] m_pc = 64'd0;
  logic [63:0] m_req = 64'd0;
  bit          m_inflight = 1'b0;
  logic [31:0] acc[$];

  // Advance the model by one clock edge, using the inputs the DUT samples.
  task automatic model_edge();
    bit          pop;
    int          used;
    logic [63:0] w;
    ent_t        e;
    if (reset) begin
      mq.delete();
      m_pc = 64'd0;
      m_inflight = 1'b0;
    end else if (bus0.redirect_valid) begin
      mq.delete();
      m_inflight = 1'b0;
      m_pc = {bus0.redirect_pc[63:2], 2'b00};
    end else begin
      pop  = (mq.size() != 0) && bus0.instr_ready;
      used = mq.size() - (pop ? 1 : 0) + (m_inflight ? 1 : 0);
      if (pop) void'(mq.pop_front());
      if (m_inflight) begin
        w = mem_word(m_req[7:2]);
        e.instr = w[31:0];
        e.pc = m_req;
        mq.push_back(e);
      end
      if (used < 2) begin
        m_inflight = 1'b1;
        m_req = m_pc;
        m_pc = m_pc + 64'd4;
      end else begin
        m_inflight = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Compare process: check dut0 against the model every cycle, and log accepted instructions.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", {63'd0, bus0.instr_valid}, {63'd0, mq.size() != 0});
      chk("m_instr", {32'd0, bus0.instr}, (mq.size() != 0) ? {32'd0, mq[0].instr} : 64'd0);
      chk("m_pc",    bus0.instr_pc, (mq.size() != 0) ? mq[0].pc : 64'd0);
      chk("m_addr",  bus0.imem_addr, {2'b00, m_pc[63:2]});
      if (bus0.instr_valid && bus0.instr_ready) acc.push_back(bus0.instr);
    end
  end

  initial begin
    reset = 1'b1;
    bus0.instr_ready = 1'b1; bus0.redirect_valid = 1'b0; bus0.redirect_pc = 64'd0;
    bus1.instr_ready = 1'b1; bus1.redirect_valid = 1'b0; bus1.redirect_pc = 64'd0;
    tick();
    chk_en = 1'b1;
    tick(); tick();
    // Reset state
    chk("rst_valid", {63'd0, bus0.instr_valid}, 64'd0);
    chk("rst_instr", {32'd0, bus0.instr}, 64'd0);
    chk("rst_pc", bus0.instr_pc, 64'd0);
    chk("rst_addr", bus0.imem_addr, 64'd0);
    chk("rst_addr_wrap", bus1.imem_addr, 64'h3FFF_FFFF_FFFF_FFFF);

    // Test 1: streaming with ready held high (cycle 0 = first cycle out of reset)
    reset = 1'b0;
    chk("t1_addr_c0", bus0.imem_addr, 64'd0);
    tick();
    chk("t1_addr_c1", bus0.imem_addr, 64'd1);
    chk("t1_valid_c1", {63'd0, bus0.instr_valid}, 64'd0);
    tick();
    chk("t1_valid_c2", {63'd0, bus0.instr_valid}, 64'd1);
    chk("t1_instr_c2", {32'd0, bus0.instr}, 64'd100);
    chk("t1_pc_c2", bus0.instr_pc, 64'd0);
    chk("t5_pc_c2", bus1.instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t5_instr_c2", {32'd0, bus1.instr}, 64'd163);
    tick();
    chk("t1_instr_c3", {32'd0, bus0.instr}, 64'd101);
    chk("t1_pc_c3", bus0.instr_pc, 64'd4);
    chk("t5_pc_c3", bus1.instr_pc, 64'd0);
    chk("t5_instr_c3", {32'd0, bus1.instr}, 64'd100);
    tick();
    chk("t1_instr_c4", {32'd0, bus0.instr}, 64'd102);
    chk("t1_pc_c4", bus0.instr_pc, 64'd8);

    // Test 2: backpressure fills the FIFO and freezes the address
    reset = 1'b1; tick();
    reset = 1'b0; bus0.instr_ready = 1'b0; acc.delete();
    repeat (5) tick();
    chk("t2_valid", {63'd0, bus0.instr_valid}, 64'd1);
    chk("t2_instr_hold", {32'd0, bus0.instr}, 64'd100);
    chk("t2_pc_hold", bus0.instr_pc, 64'd0);
    chk("t2_addr_frozen", bus0.imem_addr, 64'd2);
    bus0.instr_ready = 1'b1;
    repeat (4) tick();
    chk("t2_acc_n", 64'(acc.size()), 64'd4);
    chk("t2_acc0", {32'd0, acc[0]}, 64'd100);
    chk("t2_acc1", {32'd0, acc[1]}, 64'd101);
    chk("t2_acc2", {32'd0, acc[2]}, 64'd102);

    // Test 3: redirect with a response in flight
    reset = 1'b1; tick();
    reset = 1'b0; bus0.instr_ready = 1'b0;
    tick(); tick();
    bus0.redirect_valid = 1'b1; bus0.redirect_pc = 64'h40;
    tick();
    bus0.redirect_valid = 1'b0;
    chk("t3_addr", bus0.imem_addr, 64'd16);
    chk("t3_flush", {63'd0, bus0.instr_valid}, 64'd0);
    tick();
    chk("t3_gap", {63'd0, bus0.instr_valid}, 64'd0);
    tick();
    chk("t3_valid", {63'd0, bus0.instr_valid}, 64'd1);
    chk("t3_instr", {32'd0, bus0.instr}, 64'd116);
    chk("t3_pc", bus0.instr_pc, 64'h40);
    tick();
    chk("t3_full_addr", bus0.imem_addr, 64'd18);

    // Test 4: misaligned redirect while full, with a concurrent pop
    acc.delete();
    bus0.instr_ready = 1'b1; bus0.redirect_valid = 1'b1; bus0.redirect_pc = 64'h43;
    tick();
    bus0.redirect_valid = 1'b0;
    chk("t4_addr", bus0.imem_addr, 64'd16);
    chk("t4_flush", {63'd0, bus0.instr_valid}, 64'd0);
    chk("t4_pop_done", {32'd0, acc[0]}, 64'd116);
    tick(); tick();
    chk("t4_instr", {32'd0, bus0.instr}, 64'd116);
    chk("t4_pc", bus0.instr_pc, 64'h40);
    tick();
    chk("t4_pc_next", bus0.instr_pc, 64'h44);

    // Test 6: reset together with redirect, mid-stream
    reset = 1'b1; bus0.redirect_valid = 1'b1; bus0.redirect_pc = 64'h80;
    tick();
    chk("t6_valid", {63'd0, bus0.instr_valid}, 64'd0);
    chk("t6_addr", bus0.imem_addr, 64'd0);
    reset = 1'b0; bus0.redirect_valid = 1'b0;
    tick(); tick();
    chk("t6_instr", {32'd0, bus0.instr}, 64'd100);
    chk("t6_pc", bus0.instr_pc, 64'd0);

    // Mixed ready pattern with occasional redirects, checked by the model
    for (int i = 0; i < 40; i++) begin
      bus0.instr_ready = ((i % 3) != 1);
      bus0.redirect_valid = (i == 13) || (i == 29);
      bus0.redirect_pc = (i == 13) ? 64'h1E : 64'hF9;
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
